// File: rtl/fp16_operand_loader.sv
// Operand/opcode/result register file for the fp16 FPU control FSM, with a
// debounced start strobe and a shadow copy of the FSM's load sequence.
module fp16_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic [15:0] data_in,
    input  logic [1:0]  op_in,
    input  logic        enaAFSM,
    input  logic        enaBFSM,
    input  logic        enaOFSM,
    input  logic        enaRFSM,
    input  logic        ready,
    input  logic        error,
    input  logic [15:0] result,
    output logic        start,
    output logic [17:0] A,
    output logic [17:0] B,
    output logic [1:0]  O,
    output logic [15:0] R,
    output logic [15:0] res_q,
    output logic        res_valid,
    output logic        err_flag,
    output logic [3:0]  cls_a,
    output logic [3:0]  cls_b,
    output logic        seq_err
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_A, S_B, S_OP, S_WAIT, S_DONE, S_ERR
    } shadow_t;

    // {s, e, 1'b0, hidden, f}: exponent passes through, hidden bit is e != 0
    function automatic logic [17:0] unpack(input logic [15:0] d);
        return {d[15], d[14:10], 1'b0, (d[14:10] != 5'd0), d[9:0]};
    endfunction

    // {nan, inf, sub, zero}
    function automatic logic [3:0] classify(input logic [15:0] d);
        logic e_zero, e_max, f_zero;
        e_zero = (d[14:10] == 5'd0);
        e_max  = (d[14:10] == 5'd31);
        f_zero = (d[9:0] == 10'd0);
        return {e_max & ~f_zero, e_max & f_zero, e_zero & ~f_zero, e_zero & f_zero};
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   sync_out;
    shadow_t                state_q, state_d;
    logic                   moved_q;
    logic                   wrong_state, multi_ena, new_txn;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        cnt_d    = cnt_q;
        if (!sync_out)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
        lvl_d = (DEBOUNCE_CYCLES == 0) ? sync_out : (cnt_d == CNT_MAX);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_A;
            S_A:                   if (start) state_d = S_B;
            S_B:                   if (start) state_d = S_OP;
            S_OP:                  if (start) state_d = S_WAIT;
            S_WAIT: begin
                if (error)      state_d = S_ERR;
                else if (ready) state_d = S_DONE;
            end
            default:               state_d = S_IDLE;
        endcase
    end

    assign wrong_state = (enaAFSM && state_q != S_A) ||
                         (enaBFSM && state_q != S_B) ||
                         (enaOFSM && state_q != S_OP);
    assign multi_ena   = $countones({enaAFSM, enaBFSM, enaOFSM, enaRFSM}) > 1;
    assign new_txn     = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            lvl_q     <= 1'b0;
            start     <= 1'b0;
            state_q   <= S_IDLE;
            moved_q   <= 1'b0;
            A         <= '0;
            B         <= '0;
            O         <= '0;
            R         <= '0;
            cls_a     <= '0;
            cls_b     <= '0;
            res_q     <= '0;
            res_valid <= 1'b0;
            err_flag  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_start};
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            start   <= lvl_d & ~lvl_q;
            state_q <= state_d;
            moved_q <= (state_d != state_q);

            if (enaAFSM) begin
                A     <= unpack(data_in);
                cls_a <= classify(data_in);
            end
            if (enaBFSM) begin
                B     <= unpack(data_in);
                cls_b <= classify(data_in);
            end
            if (enaOFSM) O <= op_in;
            if (enaRFSM) R <= result;

            // The FSM decodes its state a cycle late, so skip the check right after a move
            if ((wrong_state && !moved_q) || multi_ena)
                seq_err <= 1'b1;

            if (error) begin
                err_flag <= 1'b1;
            end else if (ready) begin
                res_q     <= R;
                res_valid <= 1'b1;
            end

            if (new_txn) begin
                res_valid <= 1'b0;
                err_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp16_operand_loader.sv
// Directed bench for fp16_operand_loader: start debounce, operand unpack and
// classification, result hold, error priority, sequence checking and reset.
module tb_fp16_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic [15:0] data_in;
    logic [1:0]  op_in;
    logic        enaAFSM, enaBFSM, enaOFSM, enaRFSM;
    logic        ready, error;
    logic [15:0] result;
    logic        start;
    logic [17:0] A, B;
    logic [1:0]  O;
    logic [15:0] R, res_q;
    logic        res_valid, err_flag, seq_err;
    logic [3:0]  cls_a, cls_b;

    int n_assert = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    fp16_operand_loader #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .data_in(data_in), .op_in(op_in),
        .enaAFSM(enaAFSM), .enaBFSM(enaBFSM), .enaOFSM(enaOFSM), .enaRFSM(enaRFSM),
        .ready(ready), .error(error), .result(result), .start(start),
        .A(A), .B(B), .O(O), .R(R), .res_q(res_q), .res_valid(res_valid),
        .err_flag(err_flag), .cls_a(cls_a), .cls_b(cls_b), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the button until start appears (six edges with a 2-stage sync and
    // 4-cycle filter), keep holding to prove no repeat strobe, then release.
    task automatic press();
        int n;
        int cnt0;
        cnt0 = start_cnt;
        n = 0;
        btn_start = 1'b1;
        while (n < 20 && start !== 1'b1) begin
            tick();
            n++;
        end
        check("start_latency", n, 6);
        tick();
        check("start_width", {31'd0, start}, 0);
        repeat (6) tick();
        btn_start = 1'b0;
        repeat (4) tick();
        check("start_single", start_cnt - cnt0, 1);
    endtask

    initial begin
        rst = 1'b0;
        btn_start = 1'b0;
        data_in = '0;
        op_in = '0;
        {enaAFSM, enaBFSM, enaOFSM, enaRFSM} = '0;
        ready = 1'b0;
        error = 1'b0;
        result = '0;
        repeat (2) tick();

        // Reset values
        check("rst_start", {31'd0, start}, 0);
        check("rst_A", {14'd0, A}, 0);
        check("rst_res_q", {16'd0, res_q}, 0);
        check("rst_flags", {28'd0, res_valid, err_flag, seq_err, start}, 0);
        rst = 1'b1;
        repeat (2) tick();

        // Three-cycle glitch is filtered out
        btn_start = 1'b1;
        repeat (3) tick();
        btn_start = 1'b0;
        repeat (8) tick();
        check("glitch_no_start", start_cnt, 0);

        // Real press -> S_A, load A
        press();
        data_in = 16'h3C00;
        enaAFSM = 1'b1;
        tick();
        enaAFSM = 1'b0;
        check("A_3c00", {14'd0, A}, 32'h0F400);
        check("cls_a_3c00", {28'd0, cls_a}, 4'b0000);

        // S_B, load B
        press();
        data_in = 16'h4000;
        enaBFSM = 1'b1;
        tick();
        enaBFSM = 1'b0;
        check("B_4000", {14'd0, B}, 32'h10400);
        check("cls_b_4000", {28'd0, cls_b}, 4'b0000);

        // S_OP, opcode enable held two cycles; the last sample wins
        press();
        enaOFSM = 1'b1;
        op_in = 2'b11;
        tick();
        check("O_first", {30'd0, O}, 2'b11);
        op_in = 2'b00;
        tick();
        enaOFSM = 1'b0;
        op_in = 2'b10;
        tick();
        check("O_last", {30'd0, O}, 2'b00);

        // S_WAIT: result then ready two cycles later
        press();
        check("seq_err_clean", {31'd0, seq_err}, 0);
        result = 16'h4200;
        enaRFSM = 1'b1;
        tick();
        enaRFSM = 1'b0;
        result = 16'hFFFF;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("R_4200", {16'd0, R}, 32'h4200);
        check("res_q_4200", {16'd0, res_q}, 32'h4200);
        check("res_valid_done", {31'd0, res_valid}, 1);
        check("err_flag_done", {31'd0, err_flag}, 0);

        // New transaction from S_DONE clears valid but keeps the displayed value
        press();
        check("res_valid_cleared", {31'd0, res_valid}, 0);
        check("res_q_held", {16'd0, res_q}, 32'h4200);

        // Classification sweep with enaAFSM held across cycles (in S_A)
        enaAFSM = 1'b1;
        data_in = 16'h0000; tick();
        check("A_0000", {14'd0, A}, 32'h00000);
        check("cls_0000", {28'd0, cls_a}, 4'b0001);
        data_in = 16'h7C00; tick();
        check("A_7c00", {14'd0, A}, 32'h1F400);
        check("cls_7c00", {28'd0, cls_a}, 4'b0100);
        data_in = 16'h7E00; tick();
        check("A_7e00", {14'd0, A}, 32'h1F600);
        check("cls_7e00", {28'd0, cls_a}, 4'b1000);
        data_in = 16'h8000; tick();
        check("A_8000", {14'd0, A}, 32'h20000);
        check("cls_8000", {28'd0, cls_a}, 4'b0001);
        data_in = 16'h0001; tick();
        check("A_0001", {14'd0, A}, 32'h00001);
        check("cls_0001", {28'd0, cls_a}, 4'b0010);
        enaAFSM = 1'b0;
        tick();
        check("seq_err_A_ok", {31'd0, seq_err}, 0);

        // enaBFSM in S_A flags a sequence error that survives the next start
        data_in = 16'h03FF;
        enaBFSM = 1'b1;
        tick();
        enaBFSM = 1'b0;
        check("seq_err_set", {31'd0, seq_err}, 1);
        check("cls_b_03ff", {28'd0, cls_b}, 4'b0010);
        check("B_03ff", {14'd0, B}, 32'h003FF);
        press();
        check("seq_err_sticky", {31'd0, seq_err}, 1);

        // Through to S_WAIT; ready and error together -> error wins
        press();
        press();
        result = 16'h1234;
        enaRFSM = 1'b1;
        tick();
        enaRFSM = 1'b0;
        ready = 1'b1;
        error = 1'b1;
        tick();
        ready = 1'b0;
        error = 1'b0;
        check("err_flag_set", {31'd0, err_flag}, 1);
        check("res_valid_err", {31'd0, res_valid}, 0);
        check("res_q_not_updated", {16'd0, res_q}, 32'h4200);

        // New transaction from S_ERR clears the error flag
        press();
        check("err_flag_cleared", {31'd0, err_flag}, 0);

        // Move to S_B with A loaded, then reset mid-cycle
        data_in = 16'h3C00;
        enaAFSM = 1'b1;
        tick();
        enaAFSM = 1'b0;
        press();
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_A", {14'd0, A}, 0);
        check("mid_rst_R", {16'd0, R}, 0);
        check("mid_rst_res_q", {16'd0, res_q}, 0);
        check("mid_rst_flags", {27'd0, seq_err, err_flag, res_valid, start, |O}, 0);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // Fresh press after reset lands in S_A: loading A raises no sequence error
        press();
        data_in = 16'h4000;
        enaAFSM = 1'b1;
        tick();
        enaAFSM = 1'b0;
        tick();
        check("post_rst_seq_err", {31'd0, seq_err}, 0);
        check("post_rst_A", {14'd0, A}, 32'h10400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp16_operand_loader.md
Name: fp16_operand_loader

Overview:
- Counterpart to the FPU control FSM. Generates the single-cycle `start` strobe from a raw push-button.
- Captures the 16-bit half-precision operand and the opcode when the FSM enables fire. Unpacks operands into the FSM's 18-bit extended format and returns the computed result via the R register.
- Holds a user-visible result/error until the next transaction. Tracks the FSM's load sequence with a shadow state machine and flags desynchronisation.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high cycles required before a press is accepted. 0 disables the filter.
- SYNC_STAGES, 2: flip-flop stages on `btn_start`; minimum 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- btn_start  in  1  raw, asynchronous push-button
- data_in  in  16  fp16 operand {s, e[4:0], f[9:0]}
- op_in  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div
- enaAFSM / enaBFSM / enaOFSM / enaRFSM  in  1 each  capture enables from the FSM
- ready  in  1  FSM done strobe
- error  in  1  FSM error level
- result  in  16  FSM result bus
- start  out  1  one-cycle request strobe to the FSM
- A, B  out  18  unpacked operands {s, e[4:0], 1'b0, h, f[9:0]}
- O  out  2  registered opcode
- R  out  16  registered result fed back to the FSM
- res_q  out  16  held result for display
- res_valid  out  1  res_q holds a completed result
- err_flag  out  1  last transaction ended in error
- cls_a, cls_b  out  4 each  {nan, inf, sub, zero} of the captured operand
- seq_err  out  1  sticky: an enable arrived in the wrong shadow state

Behaviour:
- Reset (rst low, async): all outputs 0, shadow state S_IDLE, synchroniser and debounce counter cleared. Takes effect mid-operation immediately. After release the block waits for a fresh press.
- Start path:
  - `btn_start` passes through SYNC_STAGES flops, then the debounce counter; the counter saturates and resets on any low sample.
  - Accepted level rises → `start` is high for exactly 1 cycle (registered).
  - A held button produces no further strobes; release and re-press is required.
  - With DEBOUNCE_CYCLES=0 and SYNC_STAGES=2, `start` is high in the 3rd cycle after btn_start is first sampled high.
- Unpack (combinational from data_in, registered on capture):
  - h = (e != 0).
  - cls: zero = e==0 & f==0; sub = e==0 & f!=0; inf = e==31 & f==0; nan = e==31 & f!=0.
  - Exponent is passed unmodified.
- Capture:
  - Each cycle enaAFSM=1 → A, cls_a load. The enable may persist multiple cycles; the last sampled data wins.
  - Same rule: enaBFSM → B, cls_b; enaOFSM → O <= op_in; enaRFSM → R <= result.
  - If more than one enable is high in the same cycle, each target still loads and seq_err is set.
- Shadow FSM:
  - S_IDLE –start→ S_A –start→ S_B –start→ S_OP –start→ S_WAIT.
  - S_WAIT: ready → S_DONE; error → S_ERR.
  - S_DONE / S_ERR –start→ S_A, same edge as the FSM leaving IDLE.
  - On start from S_IDLE/S_DONE/S_ERR: res_valid <= 0 and err_flag <= 0.
- ready=1: res_q <= R, res_valid <= 1. Because R is registered, res_q holds the value captured on the earlier enaRFSM cycle.
- error=1: err_flag <= 1, res_valid unchanged (0).
- ready and error in the same cycle: error wins, res_q is not updated.
- seq_err:
  - Set if enaAFSM is high outside S_A, enaBFSM outside S_B, or enaOFSM outside S_OP.
  - The check is applied one cycle after each shadow transition, to tolerate the FSM's one-cycle decode lag.
  - Cleared only by reset.
- start arriving in S_WAIT is ignored by the shadow FSM; it is still forwarded to the FSM.

Test Plan:
1. Reset mid-S_B with A loaded → all outputs 0 immediately; state S_IDLE; next press produces a single start.
2. DEBOUNCE_CYCLES=4, btn high 3 cycles then low, then high 10 cycles → exactly one start, asserted after the 4th stable cycle.
3. Load data_in=16'h3C00 on enaAFSM, 16'h4000 on enaBFSM, op 00 → A=18'h0F400, B=18'h10400, O=00; cls_a=cls_b=0000.
4. Then FSM enaRFSM with result=16'h4200, ready two cycles later → R=16'h4200, res_q=16'h4200, res_valid=1, err_flag=0.
5. Operands 16'h0000, 16'h7C00, 16'h7E00, 16'h8000, 16'h0001 → cls 0001, 0100, 1000, 0001, 0010. A for 16'h8000 is 18'h20000; A for 16'h0001 is 18'h00001.
6. enaBFSM pulsed while shadow is S_A → seq_err=1, sticky through the next start. ready+error in the same cycle → err_flag=1, res_valid=0.
